// File: rtl/id_stage.sv
// RISC-V decode stage: field split, immediate generation, load-use stall and a one-entry ID/EX register.
// Optional macro ID_WB_BYPASS_EN forwards the writeback port onto matching source operands.
module id_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid,
   input  logic [DATA_WIDTH-1:0]    if_instr,
   input  logic [DATA_WIDTH-1:0]    if_pc,
   output logic                     id_ready,
   input  logic                     flush,
   output logic [ADDRESS_WIDTH-1:0] rg_rd_addr1,
   output logic [ADDRESS_WIDTH-1:0] rg_rd_addr2,
   input  logic [DATA_WIDTH-1:0]    rg_rd_data1,
   input  logic [DATA_WIDTH-1:0]    rg_rd_data2,
   input  logic                     wb_en,
   input  logic [ADDRESS_WIDTH-1:0] wb_dest,
   input  logic [DATA_WIDTH-1:0]    wb_data,
   input  logic                     ex_ready,
   output logic                     ex_valid,
   output logic [DATA_WIDTH-1:0]    ex_pc,
   output logic [DATA_WIDTH-1:0]    ex_rs1_data,
   output logic [DATA_WIDTH-1:0]    ex_rs2_data,
   output logic [DATA_WIDTH-1:0]    ex_imm,
   output logic [ADDRESS_WIDTH-1:0] ex_rs1,
   output logic [ADDRESS_WIDTH-1:0] ex_rs2,
   output logic [ADDRESS_WIDTH-1:0] ex_rd,
   output logic [6:0]               ex_opcode,
   output logic [2:0]               ex_funct3,
   output logic                     ex_funct7b5,
   output logic                     ex_illegal
);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   function automatic logic [DATA_WIDTH-1:0] gen_imm(input logic [DATA_WIDTH-1:0] ins);
      logic [DATA_WIDTH-1:0] imm;
      case (ins[6:0])
         OP_LOAD, OP_IMM, OP_JALR: imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:20]};
         OP_STORE:                 imm = {{(DATA_WIDTH-12){ins[31]}}, ins[31:25], ins[11:7]};
         OP_BRANCH:                imm = {{(DATA_WIDTH-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'h000};
         OP_JAL:                   imm = {{(DATA_WIDTH-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
         default:                  imm = '0;
      endcase
      return imm;
   endfunction

   logic [6:0]               opcode_s;
   logic [ADDRESS_WIDTH-1:0] rs1_s, rs2_s, rd_s;
   logic [DATA_WIDTH-1:0]    imm_s, op1_s, op2_s;
   logic                     illegal_s, use_rs1_s, use_rs2_s, hazard_s, capture_s;

   assign opcode_s    = if_instr[6:0];
   assign rs1_s       = if_instr[15 +: ADDRESS_WIDTH];
   assign rs2_s       = if_instr[20 +: ADDRESS_WIDTH];
   assign rd_s        = if_instr[7 +: ADDRESS_WIDTH];
   assign rg_rd_addr1 = rs1_s;
   assign rg_rd_addr2 = rs2_s;

   // opcode classification: legality and which source registers are read
   always_comb begin
      imm_s     = gen_imm(if_instr);
      illegal_s = 1'b1;
      use_rs1_s = 1'b0;
      use_rs2_s = 1'b0;
      case (opcode_s)
         OP_LOAD, OP_IMM, OP_JALR: begin
            illegal_s = 1'b0;
            use_rs1_s = 1'b1;
         end
         OP_STORE, OP_BRANCH, OP_OP: begin
            illegal_s = 1'b0;
            use_rs1_s = 1'b1;
            use_rs2_s = 1'b1;
         end
         OP_LUI, OP_AUIPC, OP_JAL: begin
            illegal_s = 1'b0;
         end
         default: begin
            illegal_s = 1'b1;
         end
      endcase
   end

   // operand selection; the register file does not hardwire x0, so zero it here
   always_comb begin
      op1_s = '0;
      op2_s = '0;
      if (rs1_s == '0) begin
         op1_s = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (wb_en && (wb_dest == rs1_s)) begin
         op1_s = wb_data;
`endif
      end else begin
         op1_s = rg_rd_data1;
      end
      if (rs2_s == '0) begin
         op2_s = '0;
`ifdef ID_WB_BYPASS_EN
      end else if (wb_en && (wb_dest == rs2_s)) begin
         op2_s = wb_data;
`endif
      end else begin
         op2_s = rg_rd_data2;
      end
   end

`ifndef ID_WB_BYPASS_EN
   logic unused_wb_s;
   assign unused_wb_s = ^{wb_en, wb_dest, wb_data};
`endif

   // load-use stall and handshake
   always_comb begin
      hazard_s = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != '0) &&
                 ((use_rs1_s && (rs1_s == ex_rd)) || (use_rs2_s && (rs2_s == ex_rd)));
      if (hazard_s) begin
         id_ready = 1'b0;
      end else begin
         id_ready = !ex_valid || ex_ready;
      end
      capture_s = if_valid && id_ready && !flush;
   end

   // ID/EX pipeline register; payload is held whenever nothing new is captured
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid    <= 1'b0;
         ex_pc       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_opcode   <= 7'd0;
         ex_funct3   <= 3'd0;
         ex_funct7b5 <= 1'b0;
         ex_illegal  <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (capture_s) begin
         ex_valid    <= 1'b1;
         ex_pc       <= if_pc;
         ex_rs1_data <= op1_s;
         ex_rs2_data <= op2_s;
         ex_imm      <= imm_s;
         ex_rs1      <= rs1_s;
         ex_rs2      <= rs2_s;
         ex_rd       <= rd_s;
         ex_opcode   <= opcode_s;
         ex_funct3   <= if_instr[14:12];
         ex_funct7b5 <= if_instr[30];
         ex_illegal  <= illegal_s;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end else begin
         ex_valid <= ex_valid;
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Randomized self-checking bench for id_stage against a rule-level model of the decode stage.
module tb_id_stage;

   typedef struct {
      logic        valid;
      logic [31:0] pc, d1, d2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic        f7;
      logic        ill;
   } ex_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid = 1'b0;
   logic [31:0] if_instr = 32'd0;
   logic [31:0] if_pc = 32'd0;
   logic        id_ready;
   logic        flush = 1'b0;
   logic [4:0]  rg_rd_addr1, rg_rd_addr2;
   logic [31:0] rg_rd_data1, rg_rd_data2;
   logic        wb_en = 1'b0;
   logic [4:0]  wb_dest = 5'd0;
   logic [31:0] wb_data = 32'd0;
   logic        ex_ready = 1'b0;
   logic        ex_valid;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5, ex_illegal;

   int   checks = 0;
   int   failures = 0;
   bit   live = 1'b0;
   bit   init_rf = 1'b1;
   bit   rf_block = 1'b0;
   logic last_id_ready;
   ex_t  m, m_n;
   logic [31:0] regs [0:31];
   logic [6:0]  legal_ops [0:8];

   always #5 clk = ~clk;

   id_stage dut (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(id_ready), .flush(flush), .rg_rd_addr1(rg_rd_addr1), .rg_rd_addr2(rg_rd_addr2),
      .rg_rd_data1(rg_rd_data1), .rg_rd_data2(rg_rd_data2), .wb_en(wb_en), .wb_dest(wb_dest),
      .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
      .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
      .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
   );

   // register file: writes on the falling edge, x0 deliberately not hardwired
   always @(negedge clk) begin
      if (init_rf) begin
         for (int i = 0; i < 32; i++) regs[i] <= $urandom;
         regs[0] <= 32'hDEADBEEF;
      end else if (wb_en && !rf_block) begin
         regs[wb_dest] <= wb_data;
      end
   end
   assign rg_rd_data1 = regs[rg_rd_addr1];
   assign rg_rd_data2 = regs[rg_rd_addr2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   function automatic int sext(input int v, input int bits);
      if (v >= (1 << (bits - 1))) return v - (1 << bits);
      return v;
   endfunction

   function automatic void model_decode(input logic [31:0] ins, output logic [31:0] imm,
                                        output logic ill, output logic u1, output logic u2);
      ill = 1'b0; u1 = 1'b1; u2 = 1'b0; imm = 32'd0;
      case (ins[6:0])
         7'h03, 7'h13, 7'h67: imm = 32'(sext(int'(ins[31:20]), 12));
         7'h23: begin imm = 32'(sext(int'({ins[31:25], ins[11:7]}), 12)); u2 = 1'b1; end
         7'h63: begin imm = 32'(2 * sext(int'({ins[31], ins[7], ins[30:25], ins[11:8]}), 12)); u2 = 1'b1; end
         7'h33: u2 = 1'b1;
         7'h37, 7'h17: begin imm = 32'(ins[31:12]) << 12; u1 = 1'b0; end
         7'h6F: begin imm = 32'(2 * sext(int'({ins[31], ins[19:12], ins[20], ins[30:21]}), 20)); u1 = 1'b0; end
         default: begin ill = 1'b1; u1 = 1'b0; end
      endcase
   endfunction

   function automatic logic [31:0] opnd(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
      if (wb_en && wb_dest == idx) return wb_data;
`endif
      return regs[idx];
   endfunction

   task automatic clear_model();
      m = '{valid: 1'b0, pc: 32'd0, d1: 32'd0, d2: 32'd0, imm: 32'd0, rs1: 5'd0, rs2: 5'd0,
            rd: 5'd0, op: 7'd0, f3: 3'd0, f7: 1'b0, ill: 1'b0};
      m_n = m;
   endtask

   // one cycle: check combinational outputs after the rf write, predict next state, advance
   task automatic step();
      logic [31:0] imm;
      logic ill, u1, u2, haz, exp_ready;
      @(negedge clk);
      #1;
      model_decode(if_instr, imm, ill, u1, u2);
      haz = m.valid && m.op == 7'h03 && m.rd != 5'd0 &&
            ((u1 && if_instr[19:15] == m.rd) || (u2 && if_instr[24:20] == m.rd));
      exp_ready = haz ? 1'b0 : (!m.valid || ex_ready);
      last_id_ready = id_ready;
      chk("id_ready", 32'(id_ready), 32'(exp_ready));
      chk("rg_rd_addr1", 32'(rg_rd_addr1), 32'(if_instr[19:15]));
      chk("rg_rd_addr2", 32'(rg_rd_addr2), 32'(if_instr[24:20]));
      m_n = m;
      if (flush) begin
         m_n.valid = 1'b0;
      end else if (if_valid && exp_ready) begin
         m_n = '{valid: 1'b1, pc: if_pc, d1: opnd(if_instr[19:15]), d2: opnd(if_instr[24:20]),
                 imm: imm, rs1: if_instr[19:15], rs2: if_instr[24:20], rd: if_instr[11:7],
                 op: if_instr[6:0], f3: if_instr[14:12], f7: if_instr[30], ill: ill};
      end else if (ex_ready) begin
         m_n.valid = 1'b0;
      end
      @(posedge clk);
      m = m_n;
      #2;
   endtask

   // compare process: registered outputs against the model after every rising edge
   always @(posedge clk) begin
      #1;
      if (live && !rst) begin
         chk("ex_valid", 32'(ex_valid), 32'(m.valid));
         chk("ex_pc", ex_pc, m.pc);
         chk("ex_rs1_data", ex_rs1_data, m.d1);
         chk("ex_rs2_data", ex_rs2_data, m.d2);
         chk("ex_imm", ex_imm, m.imm);
         chk("ex_rs1", 32'(ex_rs1), 32'(m.rs1));
         chk("ex_rs2", 32'(ex_rs2), 32'(m.rs2));
         chk("ex_rd", 32'(ex_rd), 32'(m.rd));
         chk("ex_opcode", 32'(ex_opcode), 32'(m.op));
         chk("ex_funct3", 32'(ex_funct3), 32'(m.f3));
         chk("ex_funct7b5", 32'(ex_funct7b5), 32'(m.f7));
         chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ins;
      legal_ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      init_rf = 1'b0;
      chk("reset_ex_valid", 32'(ex_valid), 32'd0);
      chk("reset_ex_imm", ex_imm, 32'd0);
      chk("reset_ex_pc", ex_pc, 32'd0);
      chk("reset_ex_illegal", 32'(ex_illegal), 32'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      live = 1'b1;

      // ADDI x5,x0,-1 with a corrupted x0 in the register file
      if_valid = 1'b1; ex_ready = 1'b1; if_instr = 32'hFFF00293; if_pc = 32'h100;
      step();
      chk("addi_valid", 32'(ex_valid), 32'd1);
      chk("addi_imm", ex_imm, 32'hFFFFFFFF);
      chk("addi_rs1_data_x0", ex_rs1_data, 32'd0);
      chk("addi_rd", 32'(ex_rd), 32'd5);

      // LW x7,0(x1) then dependent ADD x8,x7,x2: one bubble, then capture
      if_instr = 32'h0000A383; if_pc = 32'h104;
      step();
      chk("lw_opcode", 32'(ex_opcode), 32'h03);
      if_instr = 32'h00238433; if_pc = 32'h108;
      step();
      chk("hazard_id_ready", 32'(last_id_ready), 32'd0);
      chk("hazard_bubble", 32'(ex_valid), 32'd0);
      step();
      chk("add_id_ready", 32'(last_id_ready), 32'd1);
      chk("add_valid", 32'(ex_valid), 32'd1);
      chk("add_rd", 32'(ex_rd), 32'd8);

      // EX stalled for three cycles, then flushed
      ex_ready = 1'b0; if_instr = 32'hFFF00293; if_pc = 32'h10C;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_id_ready", 32'(last_id_ready), 32'd0);
         chk("stall_pc", ex_pc, 32'h108);
         chk("stall_rd", 32'(ex_rd), 32'd8);
      end
      flush = 1'b1;
      step();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      flush = 1'b0;

      // asynchronous reset in the middle of a cycle
      ex_ready = 1'b1;
      step();
      chk("pre_reset_valid", 32'(ex_valid), 32'd1);
      live = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_reset_valid", 32'(ex_valid), 32'd0);
      chk("async_reset_imm", ex_imm, 32'd0);
      clear_model();
      @(posedge clk);
      #2;
      rst = 1'b0;
      live = 1'b1;

`ifdef ID_WB_BYPASS_EN
      // ADD x9,x0,x3 with x3 being written this cycle and the register file still reading 0
      if_valid = 1'b0; wb_en = 1'b1; wb_dest = 5'd3; wb_data = 32'd0;
      step();
      rf_block = 1'b1; if_valid = 1'b1; if_instr = 32'h003004B3; wb_data = 32'h1234;
      step();
      chk("bypass_rs2_data", ex_rs2_data, 32'h1234);
      rf_block = 1'b0; wb_en = 1'b0;
`endif

      for (int c = 0; c < 3000; c++) begin
         ins = $urandom;
         ins[6:0] = ($urandom_range(0, 15) == 0) ? 7'($urandom) : legal_ops[$urandom_range(0, 8)];
         ins[11:7] = 5'($urandom_range(0, 7));
         ins[19:15] = 5'($urandom_range(0, 7));
         ins[24:20] = 5'($urandom_range(0, 7));
         if_instr = ins;
         if_pc = $urandom;
         if_valid = ($urandom_range(0, 9) < 7);
         ex_ready = ($urandom_range(0, 9) < 7);
         flush = ($urandom_range(0, 19) == 0);
         wb_en = ($urandom_range(0, 1) == 1);
         wb_dest = 5'($urandom_range(0, 7));
         wb_data = $urandom;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
